// File: rtl/fb_port_if.sv
// Framebuffer port bundle: scanout read path, posted pixel writes, and RAM command/data.
interface fb_port_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) ();
  logic              display_active;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Client side: scanout, pixel writer and the RAM data return.
  modport master (
    output display_active, rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  rd_data, rd_data_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  display_active, rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output rd_data, rd_data_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scanout reads always win the RAM slot, pixel
// writes are posted into a small FIFO and drain in read-free cycles. Reads that
// hit a still-buffered write return the newest buffered data.
// WBUF_DEPTH must be a power of two (2 or 4) so pointers wrap naturally.
module fb_port_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int WBUF_DEPTH = 2,
  parameter bit BLANK_ONLY = 1'b0
) (
  input  logic    clk,
  input  logic    rst,
  fb_port_if.slave bus
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WBUF_DEPTH);

  logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] fifo_data [WBUF_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;

  logic              fifo_empty, accept, drain_ok, do_write, bypass, pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  logic              s1_valid, s1_hit, s2_valid, s2_hit;
  logic [DATA_W-1:0] s1_data, s2_data;

  // Handshake and slot decision; an empty FIFO lets an accepted write go straight to RAM.
  always_comb begin
    fifo_empty   = (count == '0);
    bus.wr_ready = (count < FULL) && !rst;
    accept       = bus.wr_valid && bus.wr_ready;
    drain_ok     = !BLANK_ONLY || !bus.display_active;
    do_write     = !bus.rd_req && drain_ok && (!fifo_empty || accept);
    bypass       = do_write && fifo_empty;
    pop          = do_write && !fifo_empty;
  end

  // Forwarding lookup, scanned oldest to newest so the newest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (fifo_addr[rptr + PTR_W'(i)] == bus.rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[rptr + PTR_W'(i)];
      end
    end
  end

  // Posted-write FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (accept && !bypass) begin
        fifo_addr[wptr] <= bus.wr_addr;
        fifo_data[wptr] <= bus.wr_data;
        wptr            <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count <= count + CNT_W'(accept && !bypass) - CNT_W'(pop);
    end
  end

  // RAM command register: read slot first, then a drained or bypassed write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en <= bus.rd_req || do_write;
      bus.mem_we <= do_write;
      if (bus.rd_req) begin
        bus.mem_addr <= bus.rd_addr;
      end else if (do_write) begin
        bus.mem_addr  <= bypass ? bus.wr_addr : fifo_addr[rptr];
        bus.mem_wdata <= bypass ? bus.wr_data : fifo_data[rptr];
      end
    end
  end

  // Read return pipeline: request, RAM access, data capture; forwarded data replaces RAM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid          <= 1'b0;
      s1_hit            <= 1'b0;
      s1_data           <= '0;
      s2_valid          <= 1'b0;
      s2_hit            <= 1'b0;
      s2_data           <= '0;
      bus.rd_data_valid <= 1'b0;
      bus.rd_data       <= '0;
    end else begin
      s1_valid          <= bus.rd_req;
      s1_hit            <= bus.rd_req && fwd_hit;
      s1_data           <= fwd_data;
      s2_valid          <= s1_valid;
      s2_hit            <= s1_hit;
      s2_data           <= s1_data;
      bus.rd_data_valid <= s2_valid;
      if (s2_valid) begin
        bus.rd_data <= s2_hit ? s2_data : bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: one instance draining freely, one draining only in blanking.
module tb_fb_port_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  fb_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bi ();
  fb_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bb ();

  fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(2), .BLANK_ONLY(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bi)
  );

  fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(2), .BLANK_ONLY(1'b1)) u_blank (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_init(input int a);
    return 8'(a * 7 + 3);
  endfunction

  // Synchronous single-port RAM model; unwritten words hold a known pattern.
  logic [7:0] ram [int];
  logic [7:0] ram_q = '0;
  always @(posedge clk) begin
    if (bi.mem_en) begin
      if (bi.mem_we) ram[int'(bi.mem_addr)] = bi.mem_wdata;
      else ram_q <= ram.exists(int'(bi.mem_addr)) ? ram[int'(bi.mem_addr)] : ram_init(int'(bi.mem_addr));
    end
  end
  assign bi.mem_rdata = ram_q;
  assign bb.mem_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bi.display_active = 1'b0; bi.rd_req = 1'b0; bi.rd_addr = '0;
    bi.wr_valid = 1'b0; bi.wr_addr = '0; bi.wr_data = '0;
    bb.display_active = 1'b0; bb.rd_req = 1'b0; bb.rd_addr = '0;
    bb.wr_valid = 1'b0; bb.wr_addr = '0; bb.wr_data = '0;
    #12;

    // T1: reset state and wr_ready release
    chk("t1_mem_en", bi.mem_en, 0);
    chk("t1_mem_we", bi.mem_we, 0);
    chk("t1_mem_addr", bi.mem_addr, 0);
    chk("t1_mem_wdata", bi.mem_wdata, 0);
    chk("t1_rd_data", bi.rd_data, 0);
    chk("t1_rd_valid", bi.rd_data_valid, 0);
    chk("t1_wr_ready_rst", bi.wr_ready, 0);
    rst = 1'b0;
    #1;
    chk("t1_wr_ready_rel", bi.wr_ready, 1);
    step();

    // T2: single write with no reads goes out the next cycle
    bi.wr_valid = 1'b1; bi.wr_addr = 15'h0010; bi.wr_data = 8'hA5;
    step();
    bi.wr_valid = 1'b0;
    chk("t2_mem_en", bi.mem_en, 1);
    chk("t2_mem_we", bi.mem_we, 1);
    chk("t2_mem_addr", bi.mem_addr, 15'h0010);
    chk("t2_mem_wdata", bi.mem_wdata, 8'hA5);
    step();
    chk("t2_mem_en_off", bi.mem_en, 0);
    chk("t2_mem_we_off", bi.mem_we, 0);
    chk("t2_mem_addr_hold", bi.mem_addr, 15'h0010);

    // T3: reads every other edge, writes fill the gaps
    for (int c = 0; c < 12; c++) begin
      bi.rd_req   = (c < 10) && (c % 2 == 0);
      bi.rd_addr  = 15'(c / 2);
      bi.wr_valid = (c < 10) && (c % 2 == 0);
      bi.wr_addr  = 15'(32'h200 + c / 2);
      bi.wr_data  = 8'(32'h30 + c / 2);
      if (c < 10) chk("t3_wr_ready", bi.wr_ready, 1);
      step();
      if (c < 10) begin
        chk("t3_mem_en", bi.mem_en, 1);
        if (c % 2 == 0) begin
          chk("t3_rd_we", bi.mem_we, 0);
          chk("t3_rd_addr", bi.mem_addr, 32'(c / 2));
        end else begin
          chk("t3_wr_we", bi.mem_we, 1);
          chk("t3_wr_addr", bi.mem_addr, 32'(32'h200 + (c - 1) / 2));
          chk("t3_wr_data", bi.mem_wdata, 32'(32'h30 + (c - 1) / 2));
        end
      end
      if (c >= 2 && (c % 2 == 0)) begin
        chk("t3_rd_valid", bi.rd_data_valid, 1);
        chk("t3_rd_data", bi.rd_data, 32'(ram_init((c - 2) / 2)));
      end else begin
        chk("t3_rd_valid_gap", bi.rd_data_valid, 0);
      end
    end

    // T4: continuous reads, forwarding of the newest buffered write
    bi.rd_req = 1'b1; bi.rd_addr = 15'h0050;
    bi.wr_valid = 1'b1; bi.wr_addr = 15'h0100; bi.wr_data = 8'h11;
    step();
    chk("t4_we_a", bi.mem_we, 0);
    bi.wr_data = 8'h22;
    step();
    chk("t4_we_b", bi.mem_we, 0);
    bi.wr_valid = 1'b0;
    chk("t4_wr_ready_full", bi.wr_ready, 0);
    bi.rd_addr = 15'h0100;
    step();
    chk("t4_we_c", bi.mem_we, 0);
    chk("t4_addr_c", bi.mem_addr, 15'h0100);
    chk("t4_valid_c", bi.rd_data_valid, 1);
    chk("t4_data_c", bi.rd_data, 8'h33);
    bi.rd_addr = 15'h0050;
    step();
    chk("t4_we_d", bi.mem_we, 0);
    chk("t4_data_d", bi.rd_data, 8'h33);
    step();
    chk("t4_valid_fwd", bi.rd_data_valid, 1);
    chk("t4_data_fwd", bi.rd_data, 8'h22);
    chk("t4_wr_ready_still", bi.wr_ready, 0);
    bi.rd_req = 1'b0;
    step();
    chk("t4_drain0_we", bi.mem_we, 1);
    chk("t4_drain0_addr", bi.mem_addr, 15'h0100);
    chk("t4_drain0_data", bi.mem_wdata, 8'h11);
    step();
    chk("t4_drain1_we", bi.mem_we, 1);
    chk("t4_drain1_data", bi.mem_wdata, 8'h22);
    step();
    chk("t4_idle_en", bi.mem_en, 0);
    chk("t4_wr_ready_back", bi.wr_ready, 1);

    // T5: blanking-only drain
    bb.display_active = 1'b1;
    bb.wr_valid = 1'b1; bb.wr_addr = 15'h0300; bb.wr_data = 8'hB0;
    step();
    chk("t5_we_0", bb.mem_we, 0);
    bb.wr_addr = 15'h0301; bb.wr_data = 8'hB1;
    step();
    chk("t5_we_1", bb.mem_we, 0);
    bb.wr_addr = 15'h0302; bb.wr_data = 8'hB2;
    chk("t5_full", bb.wr_ready, 0);
    step();
    chk("t5_we_2", bb.mem_we, 0);
    chk("t5_full_hold", bb.wr_ready, 0);
    bb.display_active = 1'b0;
    step();
    chk("t5_d0_we", bb.mem_we, 1);
    chk("t5_d0_addr", bb.mem_addr, 15'h0300);
    chk("t5_d0_data", bb.mem_wdata, 8'hB0);
    chk("t5_ready", bb.wr_ready, 1);
    step();
    bb.wr_valid = 1'b0;
    chk("t5_d1_we", bb.mem_we, 1);
    chk("t5_d1_addr", bb.mem_addr, 15'h0301);
    chk("t5_d1_data", bb.mem_wdata, 8'hB1);
    step();
    chk("t5_d2_we", bb.mem_we, 1);
    chk("t5_d2_addr", bb.mem_addr, 15'h0302);
    chk("t5_d2_data", bb.mem_wdata, 8'hB2);
    step();
    chk("t5_idle_en", bb.mem_en, 0);

    // T6: reset during an in-flight read with a buffered write
    bi.rd_req = 1'b1; bi.rd_addr = 15'h0003;
    bi.wr_valid = 1'b1; bi.wr_addr = 15'h0400; bi.wr_data = 8'h44;
    step();
    bi.wr_valid = 1'b0;
    step();
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bi.rd_data_valid, 0);
    chk("t6_rst_en", bi.mem_en, 0);
    chk("t6_rst_addr", bi.mem_addr, 0);
    chk("t6_rst_rd_data", bi.rd_data, 0);
    chk("t6_rst_ready", bi.wr_ready, 0);
    #2;
    bi.rd_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_rel_ready", bi.wr_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_valid", bi.rd_data_valid, 0);
      chk("t6_no_drain", bi.mem_en, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
